// File: rtl/axil_slot_arbiter_pkg.sv
// Shared types and bus widths for the AXI-Lite slot arbiter.
package axil_slot_arbiter_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;
  localparam int AXIL_RESP_W = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FWD  = 2'd1,
    W_RESP = 2'd2
  } write_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } read_state_e;

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin picker: the first requester above the last
// winner wins, wrapping around to the lowest requester otherwise.
module axil_rr_pick #(
  parameter int N      = 2,
  parameter int SLOT_W = 1
) (
  input  logic [N-1:0]      i_req,
  input  logic [SLOT_W-1:0] i_last,
  output logic [SLOT_W-1:0] o_gnt,
  output logic              o_any
);

  // Lowest requester overall is the wrap-around fallback; the lowest
  // requester strictly above the last winner overrides it.
  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt = SLOT_W'(i);
        o_any = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i] && (i > int'(i_last))) begin
        o_gnt = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/axil_slot_arbiter.sv
// Shares one downstream AXI-Lite slave between NUM_SLOTS upstream masters.
// Write and read paths arbitrate independently, one transaction in flight each.
//
// state  | meaning
// W_IDLE | no write granted; latch round-robin winner on any awvalid
// W_FWD  | forward AW and W of the granted slot until both have handshaken
// W_RESP | route downstream B to the granted slot
// R_IDLE | no read granted; latch round-robin winner on any arvalid
// R_ADDR | forward AR of the granted slot
// R_DATA | route downstream R to the granted slot
module axil_slot_arbiter
  import axil_slot_arbiter_pkg::*;
#(
  parameter int NUM_SLOTS = 2
) (
  input  logic                             clk_main_a0,
  input  logic                             rst_main_n,
  input  logic [NUM_SLOTS*AXIL_ADDR_W-1:0] s_awaddr,
  input  logic [NUM_SLOTS-1:0]             s_awvalid,
  output logic [NUM_SLOTS-1:0]             s_awready,
  input  logic [NUM_SLOTS*AXIL_DATA_W-1:0] s_wdata,
  input  logic [NUM_SLOTS*AXIL_STRB_W-1:0] s_wstrb,
  input  logic [NUM_SLOTS-1:0]             s_wvalid,
  output logic [NUM_SLOTS-1:0]             s_wready,
  output logic [NUM_SLOTS*AXIL_RESP_W-1:0] s_bresp,
  output logic [NUM_SLOTS-1:0]             s_bvalid,
  input  logic [NUM_SLOTS-1:0]             s_bready,
  input  logic [NUM_SLOTS*AXIL_ADDR_W-1:0] s_araddr,
  input  logic [NUM_SLOTS-1:0]             s_arvalid,
  output logic [NUM_SLOTS-1:0]             s_arready,
  output logic [NUM_SLOTS*AXIL_DATA_W-1:0] s_rdata,
  output logic [NUM_SLOTS*AXIL_RESP_W-1:0] s_rresp,
  output logic [NUM_SLOTS-1:0]             s_rvalid,
  input  logic [NUM_SLOTS-1:0]             s_rready,
  output logic [AXIL_ADDR_W-1:0]           m_awaddr,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [AXIL_DATA_W-1:0]           m_wdata,
  output logic [AXIL_STRB_W-1:0]           m_wstrb,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  input  logic [AXIL_RESP_W-1:0]           m_bresp,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  output logic [AXIL_ADDR_W-1:0]           m_araddr,
  output logic                             m_arvalid,
  input  logic                             m_arready,
  input  logic [AXIL_DATA_W-1:0]           m_rdata,
  input  logic [AXIL_RESP_W-1:0]           m_rresp,
  input  logic                             m_rvalid,
  output logic                             m_rready
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  write_state_e      r_wstate, w_wstate_nxt;
  read_state_e       r_rstate, w_rstate_nxt;
  logic [SLOT_W-1:0] r_wgnt, w_wgnt_nxt;
  logic [SLOT_W-1:0] r_rgnt, w_rgnt_nxt;
  logic [SLOT_W-1:0] r_ptr_w, w_ptr_w_nxt;
  logic [SLOT_W-1:0] r_ptr_r, w_ptr_r_nxt;
  logic              r_aw_done, w_aw_done_nxt;
  logic              r_w_done, w_w_done_nxt;

  logic [SLOT_W-1:0] w_wpick, w_rpick;
  logic              w_wany, w_rany;

  logic [AXIL_ADDR_W-1:0] w_sel_awaddr;
  logic                   w_sel_awvalid;
  logic [AXIL_DATA_W-1:0] w_sel_wdata;
  logic [AXIL_STRB_W-1:0] w_sel_wstrb;
  logic                   w_sel_wvalid;
  logic                   w_sel_bready;
  logic [AXIL_ADDR_W-1:0] w_sel_araddr;
  logic                   w_sel_arvalid;
  logic                   w_sel_rready;

  axil_rr_pick #(.N(NUM_SLOTS), .SLOT_W(SLOT_W)) u_pick_w (
    .i_req  (s_awvalid),
    .i_last (r_ptr_w),
    .o_gnt  (w_wpick),
    .o_any  (w_wany)
  );

  axil_rr_pick #(.N(NUM_SLOTS), .SLOT_W(SLOT_W)) u_pick_r (
    .i_req  (s_arvalid),
    .i_last (r_ptr_r),
    .o_gnt  (w_rpick),
    .o_any  (w_rany)
  );

  // Mux the granted slot's request-side fields for each path.
  always_comb begin
    w_sel_awaddr  = '0;
    w_sel_awvalid = 1'b0;
    w_sel_wdata   = '0;
    w_sel_wstrb   = '0;
    w_sel_wvalid  = 1'b0;
    w_sel_bready  = 1'b0;
    w_sel_araddr  = '0;
    w_sel_arvalid = 1'b0;
    w_sel_rready  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SLOT_W'(i) == r_wgnt) begin
        w_sel_awaddr  = s_awaddr[i*AXIL_ADDR_W +: AXIL_ADDR_W];
        w_sel_awvalid = s_awvalid[i];
        w_sel_wdata   = s_wdata[i*AXIL_DATA_W +: AXIL_DATA_W];
        w_sel_wstrb   = s_wstrb[i*AXIL_STRB_W +: AXIL_STRB_W];
        w_sel_wvalid  = s_wvalid[i];
        w_sel_bready  = s_bready[i];
      end
      if (SLOT_W'(i) == r_rgnt) begin
        w_sel_araddr  = s_araddr[i*AXIL_ADDR_W +: AXIL_ADDR_W];
        w_sel_arvalid = s_arvalid[i];
        w_sel_rready  = s_rready[i];
      end
    end
  end

  // Write path next-state and outputs; AW and W may finish in either order.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_wgnt_nxt    = r_wgnt;
    w_ptr_w_nxt   = r_ptr_w;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    m_awaddr      = '0;
    m_awvalid     = 1'b0;
    m_wdata       = '0;
    m_wstrb       = '0;
    m_wvalid      = 1'b0;
    m_bready      = 1'b0;
    s_awready     = '0;
    s_wready      = '0;
    s_bvalid      = '0;
    s_bresp       = '0;
    case (r_wstate)
      W_IDLE: begin
        if (w_wany) begin
          w_wgnt_nxt   = w_wpick;
          w_wstate_nxt = W_FWD;
        end
      end
      W_FWD: begin
        m_awaddr  = w_sel_awaddr;
        m_awvalid = w_sel_awvalid & ~r_aw_done;
        m_wdata   = w_sel_wdata;
        m_wstrb   = w_sel_wstrb;
        m_wvalid  = w_sel_wvalid & ~r_w_done;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == r_wgnt) begin
            s_awready[i] = m_awready & ~r_aw_done;
            s_wready[i]  = m_wready & ~r_w_done;
          end
        end
        w_aw_done_nxt = r_aw_done | (w_sel_awvalid & m_awready);
        w_w_done_nxt  = r_w_done | (w_sel_wvalid & m_wready);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        m_bready = w_sel_bready;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == r_wgnt) begin
            s_bvalid[i]                            = m_bvalid;
            s_bresp[i*AXIL_RESP_W +: AXIL_RESP_W] = m_bresp;
          end
        end
        if (m_bvalid && w_sel_bready) begin
          w_ptr_w_nxt   = r_wgnt;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read path next-state and outputs.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rgnt_nxt   = r_rgnt;
    w_ptr_r_nxt  = r_ptr_r;
    m_araddr     = '0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s_arready    = '0;
    s_rvalid     = '0;
    s_rdata      = '0;
    s_rresp      = '0;
    case (r_rstate)
      R_IDLE: begin
        if (w_rany) begin
          w_rgnt_nxt   = w_rpick;
          w_rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        m_araddr  = w_sel_araddr;
        m_arvalid = w_sel_arvalid;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == r_rgnt) begin
            s_arready[i] = m_arready;
          end
        end
        if (w_sel_arvalid && m_arready) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        m_rready = w_sel_rready;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == r_rgnt) begin
            s_rvalid[i]                            = m_rvalid;
            s_rdata[i*AXIL_DATA_W +: AXIL_DATA_W] = m_rdata;
            s_rresp[i*AXIL_RESP_W +: AXIL_RESP_W] = m_rresp;
          end
        end
        if (m_rvalid && w_sel_rready) begin
          w_ptr_r_nxt  = r_rgnt;
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // State registers; pointers reset to the top slot so slot 0 wins first.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_wgnt    <= '0;
      r_rgnt    <= '0;
      r_ptr_w   <= SLOT_W'(NUM_SLOTS - 1);
      r_ptr_r   <= SLOT_W'(NUM_SLOTS - 1);
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_rstate  <= w_rstate_nxt;
      r_wgnt    <= w_wgnt_nxt;
      r_rgnt    <= w_rgnt_nxt;
      r_ptr_w   <= w_ptr_w_nxt;
      r_ptr_r   <= w_ptr_r_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

endmodule

// File: tb/tb_axil_slot_arbiter.sv
// Scoreboard bench for axil_slot_arbiter with two upstream slots and a
// simple always-ready downstream slave model.
module tb_axil_slot_arbiter;

  localparam int NS = 2;

  logic              clk = 1'b0;
  logic              rst_main_n;
  logic [NS*32-1:0]  s_awaddr;
  logic [NS-1:0]     s_awvalid;
  logic [NS-1:0]     s_awready;
  logic [NS*32-1:0]  s_wdata;
  logic [NS*4-1:0]   s_wstrb;
  logic [NS-1:0]     s_wvalid;
  logic [NS-1:0]     s_wready;
  logic [NS*2-1:0]   s_bresp;
  logic [NS-1:0]     s_bvalid;
  logic [NS-1:0]     s_bready;
  logic [NS*32-1:0]  s_araddr;
  logic [NS-1:0]     s_arvalid;
  logic [NS-1:0]     s_arready;
  logic [NS*32-1:0]  s_rdata;
  logic [NS*2-1:0]   s_rresp;
  logic [NS-1:0]     s_rvalid;
  logic [NS-1:0]     s_rready;
  logic [31:0]       m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [31:0]       m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  axil_slot_arbiter #(.NUM_SLOTS(NS)) dut (
    .clk_main_a0 (clk),
    .rst_main_n  (rst_main_n),
    .s_awaddr    (s_awaddr),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_araddr    (s_araddr),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .m_awaddr    (m_awaddr),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // expected traffic, in the order it must appear
  logic [31:0] q_aw[$];
  logic [31:0] q_wd[$];
  logic [31:0] q_ws[$];
  logic [31:0] q_bslot[$];
  logic [31:0] q_bresp[$];
  logic [31:0] q_ar[$];
  logic [31:0] q_rslot[$];
  logic [31:0] q_rdata[$];

  // downstream slave model state
  logic [31:0] sl_awaddr = '0;
  logic [31:0] sl_araddr = '0;
  logic        sl_got_aw = 1'b0;
  logic        sl_got_w  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // One clock: sample handshakes mid-cycle, then update drivers just after the edge.
  task automatic cycle();
    logic [NS-1:0] aw_hs, w_hs, ar_hs;
    logic maw_hs, mw_hs, mar_hs, mb_hs, mr_hs;
    @(negedge clk);
    aw_hs  = s_awvalid & s_awready;
    w_hs   = s_wvalid & s_wready;
    ar_hs  = s_arvalid & s_arready;
    maw_hs = m_awvalid & m_awready;
    mw_hs  = m_wvalid & m_wready;
    mar_hs = m_arvalid & m_arready;
    mb_hs  = m_bvalid & m_bready;
    mr_hs  = m_rvalid & m_rready;
    if (maw_hs) sl_awaddr = m_awaddr;
    if (mar_hs) sl_araddr = m_araddr;
    @(posedge clk);
    #1;
    s_awvalid = s_awvalid & ~aw_hs;
    s_wvalid  = s_wvalid & ~w_hs;
    s_arvalid = s_arvalid & ~ar_hs;
    if (!rst_main_n) begin
      m_bvalid  = 1'b0;
      m_rvalid  = 1'b0;
      sl_got_aw = 1'b0;
      sl_got_w  = 1'b0;
    end else begin
      if (mb_hs) m_bvalid = 1'b0;
      if (mr_hs) m_rvalid = 1'b0;
      if (maw_hs) sl_got_aw = 1'b1;
      if (mw_hs) sl_got_w = 1'b1;
      if (sl_got_aw && sl_got_w) begin
        m_bvalid  = 1'b1;
        m_bresp   = sl_awaddr[6:5];
        sl_got_aw = 1'b0;
        sl_got_w  = 1'b0;
      end
      if (mar_hs) begin
        m_rvalid = 1'b1;
        m_rdata  = 32'hC0DE_0000 | sl_araddr;
        m_rresp  = 2'b00;
      end
    end
  endtask

  task automatic issue_wr(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] strb);
    s_awvalid[s]        = 1'b1;
    s_awaddr[s*32 +: 32] = a;
    s_wvalid[s]         = 1'b1;
    s_wdata[s*32 +: 32]  = d;
    s_wstrb[s*4 +: 4]    = strb;
    q_aw.push_back(a);
    q_wd.push_back(d);
    q_ws.push_back(32'(strb));
    q_bslot.push_back(32'(s));
    q_bresp.push_back(32'(a[6:5]));
  endtask

  task automatic issue_rd(input int s, input logic [31:0] a, input bit expect_r);
    s_arvalid[s]         = 1'b1;
    s_araddr[s*32 +: 32] = a;
    q_ar.push_back(a);
    if (expect_r) begin
      q_rslot.push_back(32'(s));
      q_rdata.push_back(32'hC0DE_0000 | a);
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      if (s_awvalid == '0 && s_wvalid == '0 && s_arvalid == '0 &&
          q_bslot.size() == 0 && q_rslot.size() == 0)
        done = 1'b1;
    end
    if (!done) fail_now({name, "_timeout"});
  endtask

  // Monitor: pop and compare whenever a transfer is seen on either side.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_main_n) begin
        if (m_awvalid && m_awready) begin
          if (q_aw.size() == 0) fail_now("aw_unexpected");
          else chk("aw_addr", m_awaddr, q_aw.pop_front());
        end
        if (m_wvalid && m_wready) begin
          if (q_wd.size() == 0) fail_now("w_unexpected");
          else begin
            chk("w_data", m_wdata, q_wd.pop_front());
            chk("w_strb", 32'(m_wstrb), q_ws.pop_front());
          end
        end
        if (m_arvalid && m_arready) begin
          if (q_ar.size() == 0) fail_now("ar_unexpected");
          else chk("ar_addr", m_araddr, q_ar.pop_front());
        end
        if (s_bvalid != '0) chk("b_onehot", 32'($countones(s_bvalid)), 32'd1);
        if (s_rvalid != '0) chk("r_onehot", 32'($countones(s_rvalid)), 32'd1);
        for (int i = 0; i < NS; i++) begin
          if (s_bvalid[i] && s_bready[i]) begin
            if (q_bslot.size() == 0) fail_now("b_unexpected");
            else begin
              chk("b_slot", 32'(i), q_bslot.pop_front());
              chk("b_resp", 32'(s_bresp[i*2 +: 2]), q_bresp.pop_front());
            end
          end
          if (s_rvalid[i] && s_rready[i]) begin
            if (q_rslot.size() == 0) fail_now("r_unexpected");
            else begin
              chk("r_slot", 32'(i), q_rslot.pop_front());
              chk("r_data", s_rdata[i*32 +: 32], q_rdata.pop_front());
              chk("r_resp", 32'(s_rresp[i*2 +: 2]), 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    bit seen;
    rst_main_n = 1'b0;
    s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0;
    s_araddr = '0; s_arvalid = '0;
    s_bready = '1; s_rready = '1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bresp = '0; m_bvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
    repeat (3) cycle();

    // reset state
    chk("rst_m_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_m_wvalid", 32'(m_wvalid), 32'd0);
    chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_m_bready", 32'(m_bready), 32'd0);
    chk("rst_m_rready", 32'(m_rready), 32'd0);
    chk("rst_s_readys", 32'({s_awready, s_wready, s_arready}), 32'd0);
    chk("rst_s_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
    chk("rst_m_awaddr", m_awaddr, 32'd0);
    rst_main_n = 1'b1;
    cycle();

    // both slots at once, twice: grants go 0,1,0,1
    issue_wr(0, 32'h0000_0100, 32'hA0A0_A0A0, 4'hF);
    issue_wr(1, 32'h0000_0144, 32'hB1B1_B1B1, 4'hC);
    wait_quiet("rr_pair1", 60);
    issue_wr(0, 32'h0000_0160, 32'hA2A2_A2A2, 4'h1);
    issue_wr(1, 32'h0000_01A4, 32'hB3B3_B3B3, 4'h8);
    wait_quiet("rr_pair2", 60);

    // single write from slot 0, AW and W together: one-cycle grant bubble
    issue_wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("lat_m_awvalid_0", 32'(m_awvalid), 32'd0);
    cycle();
    chk("lat_m_awvalid_1", 32'(m_awvalid), 32'd1);
    chk("lat_s_awready", 32'(s_awready), 32'b01);
    wait_quiet("single_wr", 40);
    chk("single_bvalid_idle", 32'(s_bvalid), 32'd0);

    // slot 1 sends W three cycles ahead of AW
    s_wvalid[1]       = 1'b1;
    s_wdata[32 +: 32] = 32'hCAFE_F00D;
    s_wstrb[4 +: 4]   = 4'h3;
    q_wd.push_back(32'hCAFE_F00D);
    q_ws.push_back(32'h3);
    q_aw.push_back(32'h0000_0020);
    q_bslot.push_back(32'd1);
    q_bresp.push_back(32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("early_w_s_wready", 32'(s_wready), 32'd0);
      chk("early_w_m_wvalid", 32'(m_wvalid), 32'd0);
      chk("early_w_m_bvalid", 32'(m_bvalid), 32'd0);
    end
    s_awvalid[1]       = 1'b1;
    s_awaddr[32 +: 32] = 32'h0000_0020;
    wait_quiet("early_w", 40);

    // concurrent read from slot 0 and write from slot 1
    issue_rd(0, 32'h0000_0004, 1'b1);
    issue_wr(1, 32'h0000_0008, 32'h1234_5678, 4'hF);
    wait_quiet("concurrent", 60);

    // upstream holds off bready for five cycles
    s_bready[0] = 1'b0;
    issue_wr(0, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (s_bvalid[0]) seen = 1'b1;
    end
    if (!seen) fail_now("bhold_bvalid_timeout");
    for (int k = 0; k < 5; k++) begin
      chk("bhold_m_bready", 32'(m_bready), 32'd0);
      chk("bhold_s_bvalid", 32'(s_bvalid), 32'b01);
      cycle();
    end
    s_bready[0] = 1'b1;
    #1;
    chk("bhold_release_m_bready", 32'(m_bready), 32'd1);
    wait_quiet("bhold", 20);
    chk("bhold_bvalid_done", 32'(s_bvalid), 32'd0);

    // reset while a read sits in R_DATA
    s_rready[1] = 1'b0;
    issue_rd(1, 32'h0000_000C, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (s_rvalid[1]) seen = 1'b1;
    end
    if (!seen) fail_now("rdata_wait_timeout");
    chk("pre_rst_s_rvalid", 32'(s_rvalid), 32'b10);
    rst_main_n = 1'b0;
    cycle();
    chk("mid_rst_s_rvalid", 32'(s_rvalid), 32'd0);
    chk("mid_rst_m_rready", 32'(m_rready), 32'd0);
    chk("mid_rst_m_arvalid", 32'(m_arvalid), 32'd0);
    chk("mid_rst_s_arready", 32'(s_arready), 32'd0);
    chk("mid_rst_w_side", 32'({m_awvalid, m_wvalid, m_bready}), 32'd0);
    rst_main_n  = 1'b1;
    s_rready[1] = 1'b1;
    cycle();
    issue_rd(1, 32'h0000_0030, 1'b1);
    cycle();
    chk("post_rst_s_arready", 32'(s_arready), 32'b10);
    wait_quiet("post_rst_rd", 40);

    chk("leftover_expect",
        32'(q_aw.size() + q_wd.size() + q_bslot.size() + q_ar.size() + q_rslot.size()),
        32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
